// File: rtl/id_pkg.sv
// Shared types and opcode constants for the instruction-decode/issue stage.
package id_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_SW      = 6'h2B;

endpackage

// File: rtl/id_decode.sv
// Combinational decode of source usage and destination register for a MIPS word.
module id_decode
  import id_pkg::*;
(
  input  logic [31:0] inst,
  output logic        use_rs,
  output logic        use_rt,
  output logic [4:0]  dest
);

  logic [5:0] opcode;

  assign opcode = inst[31:26];

  always_comb begin
    use_rs = 1'b1;
    use_rt = 1'b0;
    dest   = inst[20:16];
    unique case (opcode)
      OP_SPECIAL: begin
        use_rt = 1'b1;
        dest   = inst[15:11];
      end
      OP_BEQ, OP_BNE, OP_SW: begin
        use_rt = 1'b1;
        dest   = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: holds one instruction until its operands are ready, then issues to EXE.
// Optional operand-wait counter enabled by defining ID_STALL_CNT_EN.
module id_issue
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  raddr1,
  output logic [4:0]  raddr2,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic        rdata1_valid,
  input  logic        rdata2_valid,
  output logic [4:0]  id_dest,
  input  logic        flush,
  output logic        exe_valid,
  input  logic        exe_ready,
  output logic [31:0] exe_inst,
  output logic [31:0] exe_pc,
  output logic [31:0] exe_src1,
  output logic [31:0] exe_src2
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  state_t      state;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic        use_rs;
  logic        use_rt;
  logic [4:0]  dest;
  logic        need1;
  logic        need2;
  logic        ops_ready;
  logic        accept;

  id_decode u_decode (
    .inst   (inst_q),
    .use_rs (use_rs),
    .use_rt (use_rt),
    .dest   (dest)
  );

  assign raddr1 = inst_q[25:21];
  assign raddr2 = inst_q[20:16];

  // $0 never waits on the scoreboard and always reads as zero.
  assign need1     = use_rs && (raddr1 != 5'd0);
  assign need2     = use_rt && (raddr2 != 5'd0);
  assign ops_ready = (!need1 || rdata1_valid) && (!need2 || rdata2_valid);

  assign id_ready = !flush && ((state == EMPTY) || ((state == READY) && exe_ready));
  assign accept   = if_valid && id_ready;
  assign id_dest  = (!flush && (state == READY) && exe_ready) ? dest : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= EMPTY;
      inst_q    <= '0;
      pc_q      <= '0;
      exe_valid <= 1'b0;
      exe_inst  <= '0;
      exe_pc    <= '0;
      exe_src1  <= '0;
      exe_src2  <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      exe_valid <= 1'b0;
    end else begin
      if (accept) begin
        inst_q <= if_inst;
        pc_q   <= if_pc;
      end
      unique case (state)
        EMPTY: begin
          if (accept) state <= WAIT;
        end
        WAIT: begin
          if (ops_ready) begin
            exe_inst  <= inst_q;
            exe_pc    <= pc_q;
            exe_src1  <= need1 ? rdata1 : '0;
            exe_src2  <= need2 ? rdata2 : '0;
            exe_valid <= 1'b1;
            state     <= READY;
          end
        end
        READY: begin
          if (exe_ready) begin
            exe_valid <= 1'b0;
            state     <= accept ? WAIT : EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if ((state == WAIT) && !ops_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
